riscv_wb_stage: RTL and testbench
=================================

Name: riscv_wb_stage

Overview:
- Registered write-back stage for the RISC-V core. Replaces the purely combinational write-back select.
- Selects the register-file write data from ALU, memory, PC+4 or CSR. Waits for a memory read response when needed.
- Performs load byte/half/word(/double) extraction with sign or zero extension.
- Drives the register-file write port one cycle after the result is known. Flags misaligned/illegal loads and memory timeouts.

Parameters:
- WORD_LENGTH, 32, datapath width; legal values 32 or 64.
- MEM_TIMEOUT, 64, max cycles spent in WAIT_MEM before abort; must be >= 1.
- LANE_BITS, $clog2(WORD_LENGTH/8), derived; width of mem_addr_lo.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  instruction presented for write-back
- in_ready  output  1  stage can accept; high only in IDLE
- wb_sel  input  WB_SEL  source select: WB_ALU / WB_MEM / WB_PC / WB_CSR
- rd_addr  input  5  destination register
- rd_we  input  1  instruction writes rd
- alu_out  input  WORD_LENGTH  ALU result
- pc_plus4  input  WORD_LENGTH  return address
- csr_dout  input  WORD_LENGTH  CSR read data
- mem_funct3  input  3  load type (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU)
- mem_addr_lo  input  LANE_BITS  low address bits of the load
- mem_rvalid  input  1  memory read data valid
- mem_rdata  input  WORD_LENGTH  aligned memory word
- rf_we  output  1  register-file write strobe, single-cycle pulse
- rf_waddr  output  5  register-file write address
- rf_wdata  output  WORD_LENGTH  register-file write data
- err_access  output  1  one-cycle pulse: misaligned or illegal load
- err_timeout  output  1  one-cycle pulse: memory response timeout

Behaviour:
- Reset (async, rst=1): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, err_access=0, err_timeout=0; timeout counter=0; captured rd/funct3/addr_lo=0. in_ready=1 after reset is released.
- States: IDLE, WAIT_MEM. in_ready = (state==IDLE), combinational.
- Accept = in_valid && in_ready.
- IDLE, accept, wb_sel != WB_MEM:
  - Next edge: rf_wdata = alu_out / pc_plus4 / csr_dout per wb_sel.
  - rf_waddr = rd_addr; rf_we = rd_we && (rd_addr != 0).
  - Stay in IDLE. Back-to-back accepts every cycle are allowed.
- IDLE, accept, wb_sel == WB_MEM, access legal:
  - Capture rd_addr, rd_we, mem_funct3 and mem_addr_lo.
  - Next state WAIT_MEM; counter = 0.
- Access legality:
  - LH/LHU need addr_lo[0]==0.
  - LW/LWU need addr_lo[1:0]==0.
  - LD needs addr_lo==0.
  - LD and LWU are legal only when WORD_LENGTH==64.
  - funct3 111 is always illegal.
- Illegal access on accept: next edge err_access=1, rf_we=0. Stay IDLE.
- WAIT_MEM, mem_rvalid=1:
  - Extract the lane at byte offset addr_lo from mem_rdata.
  - Sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to WORD_LENGTH; LD passes through.
  - Next edge: rf_wdata = result; rf_we = captured rd_we && rd != 0.
  - Return to IDLE.
- WAIT_MEM, mem_rvalid=0: counter increments.
  - When counter reaches MEM_TIMEOUT-1 without rvalid: next edge err_timeout=1, rf_we=0, state IDLE.
  - A late rvalid arriving later in IDLE is ignored.
- Simultaneous events: if mem_rvalid=1 in the same cycle the counter hits its limit, the data wins and no timeout is raised.
- mem_rvalid while in IDLE is ignored.
- rf_we, err_access and err_timeout are each high for exactly one cycle per event.
- rf_wdata and rf_waddr hold their last value when rf_we=0.
- Latency:
  - Non-memory: 1 cycle from accept to rf_we.
  - Memory: 1 cycle from mem_rvalid to rf_we.
- Reset asserted mid-WAIT_MEM: immediate return to IDLE, all outputs cleared, no write issued.

Test Plan:
- WB_ALU, rd=5, alu_out=0x1234_5678, rd_we=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678. in_ready stays 1; back-to-back WB_PC (pc_plus4=0x104) also writes on the following cycle.
- LB, addr_lo=2, 3-cycle delay, then rdata=0x0080_0000 -> in_ready=0 for 3 cycles; then rf_wdata=0xFFFF_FF80, rf_we=1. Repeat with LBU -> 0x0000_0080.
- LH, addr_lo=1 -> err_access pulse next cycle, rf_we=0, in_ready stays 1. With WORD_LENGTH=32, funct3=011 -> err_access.
- LW, MEM_TIMEOUT=4, no rvalid -> err_timeout pulses after 4 WAIT_MEM cycles, no write. An rvalid 2 cycles later is ignored.
- rd=0, WB_CSR, rd_we=1 -> rf_we=0. WB_MEM with rd=0 completes the handshake, still rf_we=0.
- rst asserted in WAIT_MEM, then rvalid -> outputs 0 immediately, no rf_we pulse, in_ready=1 after release.

Source files
------------

// File: rtl/riscv_wb_stage.sv
// Registered RISC-V write-back stage: selects ALU/MEM/PC/CSR result, waits for
// load data, extracts and extends the loaded lane, and flags bad loads/timeouts.
package riscv_wb_pkg;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_t;
endpackage

module riscv_wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int MEM_TIMEOUT = 64,
  localparam int LANE_BITS = $clog2(WORD_LENGTH / 8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  wb_sel_t                wb_sel,
  input  logic [4:0]             rd_addr,
  input  logic                   rd_we,
  input  logic [WORD_LENGTH-1:0] alu_out,
  input  logic [WORD_LENGTH-1:0] pc_plus4,
  input  logic [WORD_LENGTH-1:0] csr_dout,
  input  logic [2:0]             mem_funct3,
  input  logic [LANE_BITS-1:0]   mem_addr_lo,
  input  logic                   mem_rvalid,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [WORD_LENGTH-1:0] rf_wdata,
  output logic                   err_access,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       wait_cnt;
  logic [4:0]             cap_rd;
  logic                   cap_we;
  logic [2:0]             cap_funct3;
  logic [LANE_BITS-1:0]   cap_addr_lo;
  logic                   accept;
  logic [WORD_LENGTH-1:0] sel_data;
  logic [WORD_LENGTH-1:0] load_data;

  function automatic logic access_legal(input logic [2:0] f3, input logic [LANE_BITS-1:0] lo);
    case (f3)
      3'b000, 3'b100: access_legal = 1'b1;
      3'b001, 3'b101: access_legal = ~lo[0];
      3'b010:         access_legal = (lo[1:0] == 2'b00);
      3'b110:         access_legal = (WORD_LENGTH == 64) && (lo[1:0] == 2'b00);
      3'b011:         access_legal = (WORD_LENGTH == 64) && (lo == '0);
      default:        access_legal = 1'b0;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-fill above its width.
  function automatic logic [WORD_LENGTH-1:0] load_extract(input logic [2:0] f3,
                                                          input logic [LANE_BITS-1:0] lo,
                                                          input logic [WORD_LENGTH-1:0] data);
    logic [WORD_LENGTH-1:0] s;
    logic [WORD_LENGTH-1:0] r;
    int                     nbits;
    logic                   top;
    s = data >> {lo, 3'b000};
    case (f3[1:0])
      2'b00:   begin nbits = 8;           top = s[7];  end
      2'b01:   begin nbits = 16;          top = s[15]; end
      2'b10:   begin nbits = 32;          top = s[31]; end
      default: begin nbits = WORD_LENGTH; top = 1'b0;  end
    endcase
    for (int i = 0; i < WORD_LENGTH; i++) begin
      r[i] = (i < nbits) ? s[i] : (~f3[2] & top);
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign load_data = load_extract(cap_funct3, cap_addr_lo, mem_rdata);

  always_comb begin
    sel_data = alu_out;
    case (wb_sel)
      WB_PC:   sel_data = pc_plus4;
      WB_CSR:  sel_data = csr_dout;
      default: sel_data = alu_out;
    endcase
  end

  // Write data and address only move on a real write, so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cap_rd      <= '0;
      cap_we      <= 1'b0;
      cap_funct3  <= '0;
      cap_addr_lo <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      err_access  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rf_we       <= 1'b0;
      err_access  <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (wb_sel != WB_MEM) begin
              if (rd_we && (rd_addr != 5'd0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= rd_addr;
                rf_wdata <= sel_data;
              end
            end else if (access_legal(mem_funct3, mem_addr_lo)) begin
              cap_rd      <= rd_addr;
              cap_we      <= rd_we;
              cap_funct3  <= mem_funct3;
              cap_addr_lo <= mem_addr_lo;
              wait_cnt    <= '0;
              state       <= WAIT_MEM;
            end else begin
              err_access <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            if (cap_we && (cap_rd != 5'd0)) begin
              rf_we    <= 1'b1;
              rf_waddr <= cap_rd;
              rf_wdata <= load_data;
            end
            state <= IDLE;
          end else if (wait_cnt == CNT_LIMIT) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Bench for riscv_wb_stage: directed test-plan sequences with literal
// expectations, then random traffic checked every cycle against a reference model.
module tb_riscv_wb_stage;
  import riscv_wb_pkg::*;

  localparam int WL = 32;
  localparam int TO = 4;
  localparam int LB = $clog2(WL / 8);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  wb_sel_t       wb_sel;
  logic [4:0]    rd_addr;
  logic          rd_we;
  logic [WL-1:0] alu_out;
  logic [WL-1:0] pc_plus4;
  logic [WL-1:0] csr_dout;
  logic [2:0]    mem_funct3;
  logic [LB-1:0] mem_addr_lo;
  logic          mem_rvalid;
  logic [WL-1:0] mem_rdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [WL-1:0] rf_wdata;
  logic          err_access;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  riscv_wb_stage #(.WORD_LENGTH(WL), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .rd_addr(rd_addr), .rd_we(rd_we), .alu_out(alu_out),
    .pc_plus4(pc_plus4), .csr_dout(csr_dout), .mem_funct3(mem_funct3),
    .mem_addr_lo(mem_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_access(err_access), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input wb_sel_t sel, input logic [4:0] rd,
                               input logic we, input logic [2:0] f3, input logic [LB-1:0] lo,
                               input logic rv, input logic [WL-1:0] rdata,
                               input logic [WL-1:0] alu, input logic [WL-1:0] pc,
                               input logic [WL-1:0] csr);
    in_valid    = v;
    wb_sel      = sel;
    rd_addr     = rd;
    rd_we       = we;
    mem_funct3  = f3;
    mem_addr_lo = lo;
    mem_rvalid  = rv;
    mem_rdata   = rdata;
    alu_out     = alu;
    pc_plus4    = pc;
    csr_dout    = csr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, WB_ALU, 5'd0, 1'b0, 3'd0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  // Reference model: a load is either pending or not, with a count of cycles waited.
  function automatic bit model_legal(input int f3, input int off);
    int size;
    if (f3 == 7) return 1'b0;
    size = 1 << (f3 % 4);
    if (size == 8 && WL != 64) return 1'b0;
    if (f3 == 6 && WL != 64) return 1'b0;
    return (off % size) == 0;
  endfunction

  function automatic logic [63:0] model_load(input int f3, input int off, input logic [63:0] data);
    int          size;
    logic [63:0] mask;
    logic [63:0] v;
    size = 1 << (f3 % 4);
    mask = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
    v = (data >> (8 * off)) & mask;
    if (f3 < 3 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  logic          exp_ready = 1'b1;
  logic          exp_we    = 1'b0;
  logic          exp_acc   = 1'b0;
  logic          exp_to    = 1'b0;
  logic [4:0]    exp_waddr = '0;
  logic [WL-1:0] exp_wdata = '0;
  bit            pending   = 1'b0;
  int            waited    = 0;
  int            p_rd, p_f3, p_off;
  bit            p_we;
  logic [63:0]   ld_tmp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_ready = 1'b1; exp_we = 1'b0; exp_acc = 1'b0; exp_to = 1'b0;
      exp_waddr = '0; exp_wdata = '0; pending = 1'b0; waited = 0;
    end else begin
      exp_we = 1'b0; exp_acc = 1'b0; exp_to = 1'b0;
      if (!pending) begin
        if (in_valid) begin
          if (wb_sel != WB_MEM) begin
            if (rd_we && rd_addr != 0) begin
              exp_we    = 1'b1;
              exp_waddr = rd_addr;
              exp_wdata = (wb_sel == WB_ALU) ? alu_out : (wb_sel == WB_PC) ? pc_plus4 : csr_dout;
            end
          end else if (model_legal(int'(mem_funct3), int'(mem_addr_lo))) begin
            pending = 1'b1; waited = 0;
            p_rd = int'(rd_addr); p_we = rd_we; p_f3 = int'(mem_funct3); p_off = int'(mem_addr_lo);
          end else begin
            exp_acc = 1'b1;
          end
        end
      end else if (mem_rvalid) begin
        if (p_we && p_rd != 0) begin
          ld_tmp    = model_load(p_f3, p_off, 64'(mem_rdata));
          exp_we    = 1'b1;
          exp_waddr = 5'(p_rd);
          exp_wdata = ld_tmp[WL-1:0];
        end
        pending = 1'b0;
      end else begin
        waited++;
        if (waited == TO) begin
          exp_to  = 1'b1;
          pending = 1'b0;
        end
      end
      exp_ready = !pending;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model_in_ready", in_ready, exp_ready);
      checkOutput("model_rf_we", rf_we, exp_we);
      checkOutput("model_err_access", err_access, exp_acc);
      checkOutput("model_err_timeout", err_timeout, exp_to);
      checkOutput("model_rf_waddr", rf_waddr, exp_waddr);
      checkOutput("model_rf_wdata", rf_wdata, exp_wdata);
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_rf_wdata", rf_wdata, 0);
    checkOutput("rst_rf_waddr", rf_waddr, 0);
    checkOutput("rst_err_access", err_access, 0);
    checkOutput("rst_err_timeout", err_timeout, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);

    // ALU then back-to-back PC write
    applyStimulus(1'b1, WB_ALU, 5'd5, 1'b1, 3'd0, '0, 1'b0, '0, 32'h1234_5678, '0, '0);
    @(negedge clk);
    checkOutput("alu_rf_we", rf_we, 1);
    checkOutput("alu_rf_waddr", rf_waddr, 5);
    checkOutput("alu_rf_wdata", rf_wdata, 32'h1234_5678);
    checkOutput("alu_in_ready", in_ready, 1);
    applyStimulus(1'b1, WB_PC, 5'd6, 1'b1, 3'd0, '0, 1'b0, '0, '0, 32'h104, '0);
    @(negedge clk);
    checkOutput("pc_rf_we", rf_we, 1);
    checkOutput("pc_rf_wdata", rf_wdata, 32'h104);

    // LB then LBU at byte offset 2
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, WB_MEM, 5'd7, 1'b1, (k == 0) ? 3'b000 : 3'b100, 2'd2, 1'b0, '0, '0, '0, '0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checkOutput("load_wait_in_ready", in_ready, 0);
        if (c == 2) applyStimulus(1'b0, WB_ALU, 5'd0, 1'b0, 3'd0, '0, 1'b1, 32'h0080_0000, '0, '0, '0);
        else idle();
      end
      @(negedge clk);
      idle();
      checkOutput("load_rf_we", rf_we, 1);
      checkOutput("load_rf_waddr", rf_waddr, 7);
      checkOutput("load_rf_wdata", rf_wdata, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
    end

    // Misaligned LH and LD on a 32-bit datapath
    applyStimulus(1'b1, WB_MEM, 5'd8, 1'b1, 3'b001, 2'd1, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("lh_err_access", err_access, 1);
    checkOutput("lh_rf_we", rf_we, 0);
    checkOutput("lh_in_ready", in_ready, 1);
    applyStimulus(1'b1, WB_MEM, 5'd8, 1'b1, 3'b011, 2'd0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    idle();
    checkOutput("ld32_err_access", err_access, 1);

    // LW timeout, then a late rvalid that must be ignored
    applyStimulus(1'b1, WB_MEM, 5'd9, 1'b1, 3'b010, 2'd0, 1'b0, '0, '0, '0, '0);
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      idle();
      checkOutput("to_wait_in_ready", in_ready, 0);
    end
    @(negedge clk);
    checkOutput("to_err_timeout", err_timeout, 1);
    checkOutput("to_rf_we", rf_we, 0);
    checkOutput("to_in_ready", in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, WB_ALU, 5'd0, 1'b0, 3'd0, '0, 1'b1, 32'hDEAD_BEEF, '0, '0, '0);
    @(negedge clk);
    idle();
    checkOutput("late_rvalid_rf_we", rf_we, 0);
    checkOutput("late_rvalid_err_timeout", err_timeout, 0);

    // rd = 0 never writes
    applyStimulus(1'b1, WB_CSR, 5'd0, 1'b1, 3'd0, '0, 1'b0, '0, '0, '0, 32'hCAFE_0001);
    @(negedge clk);
    checkOutput("x0_csr_rf_we", rf_we, 0);
    applyStimulus(1'b1, WB_MEM, 5'd0, 1'b1, 3'b010, 2'd0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    applyStimulus(1'b0, WB_ALU, 5'd0, 1'b0, 3'd0, '0, 1'b1, 32'h5555_AAAA, '0, '0, '0);
    @(negedge clk);
    idle();
    checkOutput("x0_mem_rf_we", rf_we, 0);
    checkOutput("x0_mem_in_ready", in_ready, 1);
    checkOutput("x0_mem_rf_wdata_hold", rf_wdata, 32'h0000_0080);

    // Reset asserted while waiting on memory
    applyStimulus(1'b1, WB_MEM, 5'd10, 1'b1, 3'b010, 2'd0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_rf_we", rf_we, 0);
    checkOutput("midrst_rf_wdata", rf_wdata, 0);
    checkOutput("midrst_rf_waddr", rf_waddr, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, WB_ALU, 5'd0, 1'b0, 3'd0, '0, 1'b1, 32'h1111_2222, '0, '0, '0);
    @(negedge clk);
    checkOutput("midrst_rvalid_rf_we", rf_we, 0);
    rst = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("postrst_in_ready", in_ready, 1);
    checkOutput("postrst_rf_we", rf_we, 0);

    // Random traffic against the model
    repeat (3000) begin
      applyStimulus($urandom_range(0, 9) < 6,
                    wb_sel_t'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    1'($urandom),
                    3'($urandom_range(0, 7)),
                    LB'($urandom),
                    $urandom_range(0, 3) == 0,
                    WL'($urandom), WL'($urandom), WL'($urandom), WL'($urandom));
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
